// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline register bank: one stall code,
// per-stage flush strobes with deferral across full stalls, sticky halt, perf counters.
package pipeline_ctrl_pkg;

   typedef enum logic [2:0] {
      NO_STALL    = 3'd0,
      IFID_STALL  = 3'd1,
      IDEX_STALL  = 3'd2,
      EXMEM_STALL = 3'd3,
      FULL_STALL  = 3'd4
   } pipe_stall_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DWAIT = 2'd1,
      ST_HALT  = 2'd2
   } ctrl_state_t;

endpackage

module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int REG_W = 5
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              ihit,
   input  logic              dmem_req,
   input  logic              dhit,
   input  logic              ex_busy,
   input  logic              idex_memread,
   input  logic [REG_W-1:0]  idex_rd,
   input  logic [REG_W-1:0]  ifid_rs,
   input  logic [REG_W-1:0]  ifid_rt,
   input  logic              id_jump,
   input  logic              mem_branch_taken,
   input  logic              wb_halt,
   output pipe_stall_t       pipe_stall,
   output logic              ifid_FLUSH,
   output logic              idex_FLUSH,
   output logic              exmem_FLUSH,
   output logic              memwb_FLUSH,
   output logic              pc_en,
   output logic              halt,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output ctrl_state_t       dbg_state_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   ctrl_state_t      state_q, state_d;
   logic [2:0]       pend_flush_q, pend_flush_d;   // {exmem, idex, ifid}
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic       dmiss;
   logic       load_use;
   logic       full_stall;
   logic [2:0] flush_req;
   logic [2:0] flush_issue;

   assign dmiss    = dmem_req & ~dhit;
   assign load_use = idex_memread & (idex_rd != '0) &
                     ((idex_rd == ifid_rs) | (idex_rd == ifid_rt));
   assign flush_req = {mem_branch_taken, mem_branch_taken, mem_branch_taken | id_jump};

   // FSM: state register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (wb_halt) begin
               state_d = ST_HALT;
            end else if (dmiss) begin
               state_d = ST_DWAIT;
            end
         end
         ST_DWAIT: begin
            if (wb_halt) begin
               state_d = ST_HALT;
            end else if (dhit) begin
               state_d = ST_RUN;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_RUN;
      endcase
   end

   // FSM: outputs (stall priority, flush issue, PC enable)
   always_comb begin
      pipe_stall  = NO_STALL;
      flush_issue = 3'b000;
      pc_en       = 1'b0;
      if ((state_q == ST_HALT) || (state_d == ST_HALT)) begin
         pipe_stall = FULL_STALL;
      end else if (dmiss) begin
         pipe_stall = FULL_STALL;
      end else if (ex_busy) begin
         pipe_stall = EXMEM_STALL;
      end else if (load_use) begin
         pipe_stall = IDEX_STALL;
      end else if (!ihit) begin
         pipe_stall = IFID_STALL;
      end
      if (pipe_stall != FULL_STALL) begin
         flush_issue = pend_flush_q | flush_req;
      end
      // A non-deferred redirect must move the PC even under a partial stall.
      if (state_q != ST_HALT) begin
         pc_en = (pipe_stall == NO_STALL) ||
                 (mem_branch_taken && (pipe_stall != FULL_STALL));
      end
   end

   assign full_stall  = (pipe_stall == FULL_STALL);
   assign ifid_FLUSH  = flush_issue[0];
   assign idex_FLUSH  = flush_issue[1];
   assign exmem_FLUSH = flush_issue[2];
   assign memwb_FLUSH = 1'b0;
   assign halt        = (state_q == ST_HALT);
   assign dbg_state_o = state_q;

   // Requests seen during a full stall wait here until the pipe can move.
   always_comb begin
      pend_flush_d = 3'b000;
      if (full_stall) begin
         pend_flush_d = pend_flush_q | flush_req;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         pend_flush_q <= 3'b000;
      end else begin
         pend_flush_q <= pend_flush_d;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (state_q != ST_HALT) begin
         if ((pipe_stall != NO_STALL) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
         end
         if ((flush_issue != 3'b000) && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus random traffic, scored against
// a cycle-level reference model through an expected-response queue.
module tb_pipeline_ctrl;
   import pipeline_ctrl_pkg::*;

   localparam int REG_W = 5;

   typedef struct packed {
      logic [2:0]  stall;
      logic [3:0]  flush;   // {memwb, exmem, idex, ifid}
      logic        pc_en;
      logic        halt;
      logic [15:0] sc;
      logic [15:0] fc;
      logic [3:0]  sc4;
      logic [3:0]  fc4;
   } exp_t;
   localparam int EXP_W = $bits(exp_t);

   logic CLK = 1'b0;
   logic nRST = 1'b0;
   logic ihit, dmem_req, dhit, ex_busy, idex_memread, id_jump, mem_branch_taken, wb_halt;
   logic [REG_W-1:0] idex_rd, ifid_rs, ifid_rt;

   pipe_stall_t pipe_stall, pipe_stall4;
   logic ifid_FLUSH, idex_FLUSH, exmem_FLUSH, memwb_FLUSH, pc_en, halt;
   logic ifid_FLUSH4, idex_FLUSH4, exmem_FLUSH4, memwb_FLUSH4, pc_en4, halt4;
   logic [15:0] stall_cnt, flush_cnt;
   logic [3:0]  stall_cnt4, flush_cnt4;
   ctrl_state_t dbg_state, dbg_state4;

   pipeline_ctrl #(.CNT_W(16), .REG_W(REG_W)) u_dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
      .ex_busy(ex_busy), .idex_memread(idex_memread), .idex_rd(idex_rd),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .id_jump(id_jump),
      .mem_branch_taken(mem_branch_taken), .wb_halt(wb_halt),
      .pipe_stall(pipe_stall), .ifid_FLUSH(ifid_FLUSH), .idex_FLUSH(idex_FLUSH),
      .exmem_FLUSH(exmem_FLUSH), .memwb_FLUSH(memwb_FLUSH), .pc_en(pc_en),
      .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
      .dbg_state_o(dbg_state)
   );

   pipeline_ctrl #(.CNT_W(4), .REG_W(REG_W)) u_dut4 (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
      .ex_busy(ex_busy), .idex_memread(idex_memread), .idex_rd(idex_rd),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .id_jump(id_jump),
      .mem_branch_taken(mem_branch_taken), .wb_halt(wb_halt),
      .pipe_stall(pipe_stall4), .ifid_FLUSH(ifid_FLUSH4), .idex_FLUSH(idex_FLUSH4),
      .exmem_FLUSH(exmem_FLUSH4), .memwb_FLUSH(memwb_FLUSH4), .pc_en(pc_en4),
      .halt(halt4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4),
      .dbg_state_o(dbg_state4)
   );

   // ---------------- clock / reset ----------------
   always #5 CLK = ~CLK;

   // ---------------- scoreboard state ----------------
   logic [EXP_W-1:0] exp_q[$];
   int tests_run = 0;
   int tests_failed = 0;

   // ---------------- reference model ----------------
   bit         m_halted;
   bit [2:0]   m_pend;      // deferred flushes: bit0 ifid, bit1 idex, bit2 exmem
   int         m_stalls;    // non-halted cycles spent stalled
   int         m_flushes;   // non-halted cycles with a flush issued

   // staged stimulus, applied just after the next rising edge
   logic s_ihit, s_dmem_req, s_dhit, s_ex_busy, s_memread, s_jump, s_mbt, s_whalt;
   logic [REG_W-1:0] s_rd, s_rs, s_rt;

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic set_idle();
      s_ihit = 1'b1; s_dmem_req = 1'b0; s_dhit = 1'b0; s_ex_busy = 1'b0;
      s_memread = 1'b0; s_jump = 1'b0; s_mbt = 1'b0; s_whalt = 1'b0;
      s_rd = '0; s_rs = '0; s_rt = '0;
   endtask

   // One cycle: apply staged inputs, predict outputs, advance the model.
   task automatic step(input bit rst_low);
      exp_t e;
      int   code;
      bit   full, lu, any;
      bit [2:0] req, iss;
      @(posedge CLK);
      #1;
      nRST = ~rst_low;
      ihit = s_ihit; dmem_req = s_dmem_req; dhit = s_dhit; ex_busy = s_ex_busy;
      idex_memread = s_memread; idex_rd = s_rd; ifid_rs = s_rs; ifid_rt = s_rt;
      id_jump = s_jump; mem_branch_taken = s_mbt; wb_halt = s_whalt;
      if (rst_low) begin
         m_halted = 0; m_pend = 0; m_stalls = 0; m_flushes = 0;
      end
      lu = s_memread && (s_rd != 0) && ((s_rd == s_rs) || (s_rd == s_rt));
      if (m_halted || s_whalt)          code = 4;
      else if (s_dmem_req && !s_dhit)   code = 4;
      else if (s_ex_busy)               code = 3;
      else if (lu)                      code = 2;
      else if (!s_ihit)                 code = 1;
      else                              code = 0;
      full = (code == 4);
      req  = {s_mbt, s_mbt, s_mbt | s_jump};
      iss  = full ? 3'b000 : (m_pend | req);
      e.stall = code[2:0];
      e.flush = {1'b0, iss};
      e.pc_en = !m_halted && ((code == 0) || (s_mbt && !full));
      e.halt  = m_halted;
      e.sc    = 16'(sat(m_stalls, 65535));
      e.fc    = 16'(sat(m_flushes, 65535));
      e.sc4   = 4'(sat(m_stalls, 15));
      e.fc4   = 4'(sat(m_flushes, 15));
      exp_q.push_back(e);
      if (!rst_low) begin
         any = (iss != 0);
         if (!m_halted) begin
            if (code != 0) m_stalls++;
            if (any) m_flushes++;
         end
         m_pend = full ? (m_pend | req) : 3'b000;
         if (s_whalt) m_halted = 1;
      end
   endtask

   // ---------------- monitor ----------------
   task automatic chk(input string name, input int got, input int want);
      tests_run++;
      if (got != want) begin
         tests_failed++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
      end
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_t'(exp_q.pop_front());
         chk("pipe_stall", int'(pipe_stall), int'(e.stall));
         chk("flushes", int'({memwb_FLUSH, exmem_FLUSH, idex_FLUSH, ifid_FLUSH}), int'(e.flush));
         chk("pc_en", int'(pc_en), int'(e.pc_en));
         chk("halt", int'(halt), int'(e.halt));
         chk("stall_cnt", int'(stall_cnt), int'(e.sc));
         chk("flush_cnt", int'(flush_cnt), int'(e.fc));
         chk("stall_cnt_w4", int'(stall_cnt4), int'(e.sc4));
         chk("flush_cnt_w4", int'(flush_cnt4), int'(e.fc4));
      end
   end

   // ---------------- driver ----------------
   initial begin
      set_idle();
      ihit = 1'b1; dmem_req = 0; dhit = 0; ex_busy = 0; idex_memread = 0;
      idex_rd = '0; ifid_rs = '0; ifid_rt = '0; id_jump = 0; mem_branch_taken = 0; wb_halt = 0;

      // reset state
      step(1); step(1);

      // data miss: 3 wait cycles then hit
      set_idle(); s_dmem_req = 1;
      repeat (3) step(0);
      s_dhit = 1; step(0);
      set_idle(); step(0);

      // load-use hazard, then same pattern with rd = 0
      set_idle(); s_memread = 1; s_rd = 5; s_rt = 5; s_rs = 2; step(0);
      s_rd = 0; s_rt = 0; step(0);
      set_idle(); step(0);

      // branch in the second cycle of a 4-cycle data wait, issued on the hit
      step(1);
      set_idle(); s_dmem_req = 1; step(0);
      s_mbt = 1; step(0);
      s_mbt = 0; step(0); step(0);
      s_dhit = 1; step(0);
      set_idle(); step(0);

      // branch + load-use, branch + fetch miss, jump alone
      s_mbt = 1; s_memread = 1; s_rd = 3; s_rs = 3; step(0);
      set_idle(); s_mbt = 1; s_ihit = 0; step(0);
      set_idle(); s_jump = 1; step(0);

      // pending flush discarded by reset taken mid-wait
      set_idle(); s_dmem_req = 1; s_mbt = 1; step(0);
      s_mbt = 0; step(0);
      set_idle(); step(1);
      step(0); step(0);

      // saturation of the narrow counter under a held fetch stall
      set_idle(); s_ihit = 0;
      repeat (20) step(0);

      // halt pulse, then branch and EX busy while halted
      set_idle(); s_whalt = 1; step(0);
      set_idle(); s_mbt = 1; s_ex_busy = 1;
      repeat (5) step(0);
      set_idle(); step(1);

      // random traffic with occasional halts and resets
      for (int i = 0; i < 3000; i++) begin
         s_ihit     = ($urandom_range(0, 3) != 0);
         s_dmem_req = ($urandom_range(0, 2) == 0);
         s_dhit     = ($urandom_range(0, 1) == 1);
         s_ex_busy  = ($urandom_range(0, 5) == 0);
         s_memread  = ($urandom_range(0, 2) == 0);
         s_rd       = REG_W'($urandom_range(0, 3));
         s_rs       = REG_W'($urandom_range(0, 3));
         s_rt       = REG_W'($urandom_range(0, 3));
         s_jump     = ($urandom_range(0, 7) == 0);
         s_mbt      = ($urandom_range(0, 7) == 0);
         s_whalt    = ($urandom_range(0, 299) == 0);
         step($urandom_range(0, 99) == 0);
      end

      set_idle(); step(0);
      repeat (3) @(posedge CLK);
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
